mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported synchronous memory between the core's instruction-fetch port and its load/store port.
- Arbitrates between the two ports and sequences each access as issue, wait and capture.
- Returns read data, or a write acknowledge, to the winning requester.
- Sits between the riscv32b fetch/LSU outputs and the unified SoC memory, so the SoC can use one RAM macro instead of two.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports. Must be 32, because the byte-strobe width is fixed at 4.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request, held until granted
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request, held until granted
- d_addr  in  ADDR_W  data address
- d_we  in  4  byte write strobes; 0 means read
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_addr  out  ADDR_W  memory address
- mem_we  out  4  memory byte write enables
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: every output is 0; state=IDLE; wait counter=0; last_winner=I, so data has priority first.
- Reset mid-transaction: any in-flight access is abandoned and no rvalid is issued for it. mem_en is 0 in the cycle after reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is present, pick a winner and assert its gnt combinationally in that cycle.
  - Latch the winner's address/strobes/data and its ID, then go to ISSUE.
  - With no request, stay in IDLE.
  - gnt is asserted only in IDLE; requests in other states are ignored.
- Arbitration:
  - Only one requester present: it wins.
  - Both present: data wins unless last_winner==D, in which case fetch wins. Under continuous contention the two ports strictly alternate.
  - last_winner updates on every grant.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_addr, mem_we and mem_wdata driven from the latched registers.
  - For a fetch, mem_we is forced to 0.
  - Then go to WAIT with counter=1.
  - mem_en, mem_we and mem_wdata are 0 in every other state.
  - mem_addr holds its last value in every other state.
- WAIT:
  - Counter increments each cycle.
  - In the cycle where counter==MEM_LAT, mem_rdata is valid. At the end of that cycle, capture it into the winner's rdata register; for writes, skip the capture. Then go to IDLE.
  - The winner's rvalid pulses high for exactly one cycle, the first IDLE cycle. A new gnt may coincide with that rvalid.
- Writes: d_rvalid pulses as a completion acknowledge. d_rdata keeps its previous value.
- Latency: gnt in cycle N; mem_en in N+1; capture at the end of N+1+MEM_LAT; rvalid in N+2+MEM_LAT.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Data holding: i_rdata and d_rdata hold their values until overwritten by their own next read.
- Address and data width: addresses and data pass unmodified, with no alignment masking. Misaligned-address handling belongs to the LSU.
- Requester rules: a requester may drop req in the cycle after gnt. A req still high after its response starts a new access.

Test Plan:
- Fetch only, MEM_LAT=1: i_req with i_addr=0x100 in cycle 0, memory returns 0x00500093 → i_gnt in cycle 0, mem_en with mem_addr=0x100 and mem_we=0 in cycle 1, i_rvalid with i_rdata=0x00500093 in cycle 3, no d_rvalid.
- Store: d_req, d_addr=0x2004, d_we=4'b0011, d_wdata=0xDEADBEEF → mem_en=1, mem_we=0011 and mem_wdata=0xDEADBEEF for one cycle; d_rvalid pulses MEM_LAT+2 cycles after d_gnt; d_rdata unchanged.
- Contention: i_req and d_req held high from reset for 4 grants → grant order D,I,D,I; each gnt exactly MEM_LAT+2 cycles after the previous one; each rvalid routed only to its owner.
- Latency sweep, MEM_LAT=3: read 0x40 → mem_en in cycle 1, capture at the end of cycle 4, rvalid in cycle 5; data presented before cycle 4 must not be captured.
- Reset mid-op: assert rst in the WAIT cycle of a load → no d_rvalid afterwards; all outputs 0 the cycle after reset; with both requests present at the next IDLE, data is granted first.
- Back-to-back: continuous d_req, sequential addresses 0x0,0x4,0x8 → a new d_gnt in the same cycle as the previous d_rvalid; mem_en never asserted in two consecutive cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous memory between fetch and load/store ports
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              win_d_q, win_d_d;
  logic              wr_q, wr_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              idle, pick_d, grant, done;
  always_comb begin
    idle        = state_q == IDLE && !rst;
    pick_d      = bus.d_req && !(bus.i_req && last_d_q);
    grant       = idle && (bus.i_req || bus.d_req);
    done        = state_q == WAIT && cnt_q == 3'(MEM_LAT);
    state_d     = state_q == IDLE ? (grant ? ISSUE : IDLE) : state_q == ISSUE ? WAIT : done ? IDLE : WAIT;
    cnt_d       = state_q == ISSUE ? 3'd1 : (state_q == WAIT && !done) ? cnt_q + 3'd1 : 3'd0;
    last_d_d    = grant ? pick_d : last_d_q;
    win_d_d     = grant ? pick_d : win_d_q;
    wr_d        = grant ? pick_d && |bus.d_we : wr_q;
    mem_en_d    = grant;
    mem_addr_d  = grant ? (pick_d ? bus.d_addr : bus.i_addr) : mem_addr_q;
    mem_we_d    = grant && pick_d ? bus.d_we : 4'h0;
    mem_wdata_d = grant && pick_d ? bus.d_wdata : '0;
    i_rvalid_d  = done && !win_d_q;
    d_rvalid_d  = done && win_d_q;
    i_rdata_d   = i_rvalid_d ? bus.mem_rdata : i_rdata_q;
    d_rdata_d   = d_rvalid_d && !wr_q ? bus.mem_rdata : d_rdata_q;
  end
  // last winner resets to fetch so that data wins the first contended grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      last_d_q    <= 1'b0;
      win_d_q     <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 4'h0;
      mem_wdata_q <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      win_d_q     <= win_d_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign bus.i_gnt     = idle && bus.i_req && !pick_d;
  assign bus.d_gnt     = idle && pick_d;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (MEM_LAT 1 and 3) against a transaction-level model, vectors and corner sequences
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int errors = 0;
  int checks = 0;
  logic        i_req[2], d_req[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2];
  logic [3:0]  d_we[2];
  logic [31:0] mrd[2] = '{32'h0, 32'h0};
  logic        i_gnt[2], i_rv[2], d_gnt[2], d_rv[2], m_en[2];
  logic [31:0] i_rd[2], d_rd[2], m_addr[2], m_wd[2];
  logic [3:0]  m_we[2];
  for (genvar g = 0; g < 2; g++) begin : u
    mem_arbiter_if bus ();
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 3)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.i_req     = i_req[g];
    assign bus.i_addr    = i_addr[g];
    assign bus.d_req     = d_req[g];
    assign bus.d_addr    = d_addr[g];
    assign bus.d_we      = d_we[g];
    assign bus.d_wdata   = d_wdata[g];
    assign bus.mem_rdata = mrd[g];
    assign i_gnt[g]  = bus.i_gnt;
    assign i_rv[g]   = bus.i_rvalid;
    assign i_rd[g]   = bus.i_rdata;
    assign d_gnt[g]  = bus.d_gnt;
    assign d_rv[g]   = bus.d_rvalid;
    assign d_rd[g]   = bus.d_rdata;
    assign m_en[g]   = bus.mem_en;
    assign m_addr[g] = bus.mem_addr;
    assign m_we[g]   = bus.mem_we;
    assign m_wd[g]   = bus.mem_wdata;
  end
  function automatic int lat(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h100 ? 32'h00500093 : ~a;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (lat%0d) got=%h want=%h cyc=%0d", nm, lat(k), act, exp, cyc);
    end
  endtask
  // transaction-level model: a grant books the memory until its response cycle
  int          free_at[2], mem_cyc[2], resp_cyc[2];
  int          iss_cyc[2] = '{-100, -100};
  logic        last_d[2], resp_d[2], resp_wr[2], n_d[2], g_i[2], g_d[2];
  logic        prev_en[2] = '{1'b0, 1'b0};
  logic [31:0] resp_addr[2], e_ird[2], e_drd[2], e_maddr[2], n_addr[2], n_wd[2], iss_addr[2];
  logic [3:0]  n_we[2];
  logic        wi, wd;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        free_at[k] = cyc + 1; last_d[k] = 1'b0; resp_cyc[k] = -1; mem_cyc[k] = -1;
        e_ird[k] = 32'h0; e_drd[k] = 32'h0; e_maddr[k] = 32'h0; g_i[k] = 1'b0; g_d[k] = 1'b0;
      end else begin
        wd = cyc >= free_at[k] && d_req[k] && !(i_req[k] && last_d[k]);
        wi = cyc >= free_at[k] && i_req[k] && !wd;
        chk("i_gnt", k, 32'(i_gnt[k]), 32'(wi));
        chk("d_gnt", k, 32'(d_gnt[k]), 32'(wd));
        if (cyc == resp_cyc[k] && !resp_d[k]) e_ird[k] = mem_val(resp_addr[k]);
        if (cyc == resp_cyc[k] && resp_d[k] && !resp_wr[k]) e_drd[k] = mem_val(resp_addr[k]);
        chk("i_rvalid", k, 32'(i_rv[k]), 32'(cyc == resp_cyc[k] && !resp_d[k]));
        chk("d_rvalid", k, 32'(d_rv[k]), 32'(cyc == resp_cyc[k] && resp_d[k]));
        chk("i_rdata", k, i_rd[k], e_ird[k]);
        chk("d_rdata", k, d_rd[k], e_drd[k]);
        if (cyc == mem_cyc[k]) e_maddr[k] = n_addr[k];
        chk("mem_en", k, 32'(m_en[k]), 32'(cyc == mem_cyc[k]));
        chk("mem_addr", k, m_addr[k], e_maddr[k]);
        chk("mem_we", k, 32'(m_we[k]), 32'(cyc == mem_cyc[k] ? n_we[k] : 4'h0));
        if (cyc != mem_cyc[k] || n_d[k]) chk("mem_wdata", k, m_wd[k], cyc == mem_cyc[k] ? n_wd[k] : 32'h0);
        if (wi || wd) begin
          last_d[k] = wd; n_d[k] = wd; n_addr[k] = wd ? d_addr[k] : i_addr[k];
          n_we[k] = wd ? d_we[k] : 4'h0; n_wd[k] = d_wdata[k];
          mem_cyc[k] = cyc + 1; resp_cyc[k] = cyc + 2 + lat(k); free_at[k] = resp_cyc[k];
          resp_d[k] = wd; resp_wr[k] = wd && d_we[k] != 4'h0; resp_addr[k] = n_addr[k];
        end
        g_i[k] = i_gnt[k]; g_d[k] = d_gnt[k];
      end
      if (m_en[k]) chk("mem_en_gap", k, 32'(prev_en[k]), 32'h0);
      prev_en[k] = m_en[k];
      if (m_en[k]) begin iss_cyc[k] = cyc; iss_addr[k] = m_addr[k]; end
      mrd[k] = cyc == iss_cyc[k] + lat(k) ? mem_val(iss_addr[k]) : $urandom;
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; @(negedge clk); tick(); rst = 1'b0;
  endtask
  task automatic wait_gnt(input int k, input bit d, output int gc);
    gc = -1;
    for (int n = 0; n < 40 && gc < 0; n++) begin
      @(negedge clk);
      if (d ? d_gnt[k] : i_gnt[k]) gc = cyc;
    end
    if (gc < 0) begin
      errors++; checks++;
      $display("FAIL gnt_timeout (lat%0d) got=none want=%s_gnt", lat(k), d ? "d" : "i");
    end
  endtask
  typedef struct {
    int          k;
    bit          d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] erd;
  } vec_t;
  vec_t tv[8];
  initial begin : main
    int gc, ec, rc, prev, who, tk;
    logic [3:0]  we_s;
    logic [31:0] wd_s;
    tv[0] = '{0, 1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'h0050_0093};
    tv[1] = '{0, 1'b1, 32'h0000_2000, 4'h0, 32'h0,         32'hFFFF_DFFF};
    tv[2] = '{0, 1'b1, 32'h0000_2004, 4'h3, 32'hDEAD_BEEF, 32'hFFFF_DFFF};
    tv[3] = '{0, 1'b1, 32'h0000_2003, 4'h0, 32'h0,         32'hFFFF_DFFC};
    tv[4] = '{1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'hFFFF_FFBF};
    tv[5] = '{1, 1'b1, 32'h0000_0080, 4'hF, 32'h1234_5678, 32'h0};
    tv[6] = '{1, 1'b1, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0000_0003};
    tv[7] = '{0, 1'b0, 32'h8000_0000, 4'h0, 32'h0,         32'h7FFF_FFFF};
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; i_addr[k] = 32'h0; d_addr[k] = 32'h0; d_we[k] = 4'h0; d_wdata[k] = 32'h0;
    end
    do_reset();
    for (int v = 0; v < 8; v++) begin
      tk = tv[v].k;
      if (tv[v].d) begin
        d_req[tk] = 1'b1; d_addr[tk] = tv[v].addr; d_we[tk] = tv[v].we; d_wdata[tk] = tv[v].wd;
      end else begin
        i_req[tk] = 1'b1; i_addr[tk] = tv[v].addr;
      end
      wait_gnt(tk, tv[v].d, gc);
      tick(); i_req[tk] = 1'b0; d_req[tk] = 1'b0;
      ec = -1; rc = -1; we_s = 4'h0; wd_s = 32'h0;
      for (int t = 0; t < 12 && rc < 0; t++) begin
        @(negedge clk);
        if (m_en[tk]) begin ec = cyc; we_s = m_we[tk]; wd_s = m_wd[tk]; end
        if (tv[v].d ? d_rv[tk] : i_rv[tk]) rc = cyc;
      end
      chk("vec_issue_lat", tk, 32'(ec - gc), 32'd1);
      chk("vec_rvalid_lat", tk, 32'(rc - gc), 32'(lat(tk) + 2));
      chk("vec_mem_we", tk, 32'(we_s), 32'(tv[v].d ? tv[v].we : 4'h0));
      if (tv[v].we != 4'h0) chk("vec_mem_wdata", tk, wd_s, tv[v].wd);
      chk("vec_rdata", tk, tv[v].d ? d_rd[tk] : i_rd[tk], tv[v].erd);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; d_req[k] = 1'b1; i_addr[k] = 32'h500; d_addr[k] = 32'h600; d_we[k] = 4'h0;
      do_reset();
      prev = -1;
      for (int n = 0; n < 4; n++) begin
        gc = -1; who = 0;
        for (int t = 0; t < 40 && gc < 0; t++) begin
          @(negedge clk);
          if (i_gnt[k] || d_gnt[k]) begin gc = cyc; who = int'(d_gnt[k]); end
        end
        chk("cont_order_is_d", k, 32'(who), 32'(n % 2 == 0));
        if (n > 0) chk("cont_spacing", k, 32'(gc - prev), 32'(lat(k) + 2));
        prev = gc;
      end
      tick(); i_req[k] = 1'b0; d_req[k] = 1'b0;
      repeat (8) tick();
    end
    do_reset();
    d_req[0] = 1'b1; d_addr[0] = 32'h300; d_we[0] = 4'h0;
    wait_gnt(0, 1'b1, gc);
    tick(); d_req[0] = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_d_rvalid", 0, 32'(d_rv[0]), 32'h0);
    chk("rst_i_rvalid", 0, 32'(i_rv[0]), 32'h0);
    chk("rst_mem_en", 0, 32'(m_en[0]), 32'h0);
    chk("rst_mem_addr", 0, m_addr[0], 32'h0);
    chk("rst_mem_we", 0, 32'(m_we[0]), 32'h0);
    chk("rst_d_rdata", 0, d_rd[0], 32'h0);
    tick(); i_req[0] = 1'b1; d_req[0] = 1'b1; i_addr[0] = 32'h704; d_addr[0] = 32'h700;
    @(negedge clk);
    chk("rst_first_d_gnt", 0, 32'(d_gnt[0]), 32'h1);
    chk("rst_first_i_gnt", 0, 32'(i_gnt[0]), 32'h0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rst_no_stale_rvalid", 0, 32'(d_rv[0]), 32'(t == 2));
    end
    tick(); d_req[0] = 1'b0;
    wait_gnt(0, 1'b0, gc);
    tick(); i_req[0] = 1'b0;
    repeat (6) tick();
    do_reset();
    d_req[0] = 1'b1; d_we[0] = 4'h0; d_addr[0] = 32'h0; prev = -1;
    for (int j = 0; j < 3; j++) begin
      wait_gnt(0, 1'b1, gc);
      chk("b2b_rvalid_with_gnt", 0, 32'(d_rv[0]), 32'(j > 0));
      if (j > 0) chk("b2b_spacing", 0, 32'(gc - prev), 32'd3);
      prev = gc;
      tick(); d_addr[0] = 32'(4 * (j + 1));
      if (j == 2) d_req[0] = 1'b0;
    end
    repeat (6) tick();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (!i_req[k] || g_i[k]) begin
          i_req[k] = $urandom_range(0, 2) != 0; i_addr[k] = $urandom;
        end
        if (!d_req[k] || g_d[k]) begin
          d_req[k] = $urandom_range(0, 2) != 0; d_addr[k] = $urandom; d_wdata[k] = $urandom;
          d_we[k] = $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'h0;
        end
      end
      rst = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin i_req[k] = 1'b0; d_req[k] = 1'b0; end
    repeat (10) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
